// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request, move-to and result signals of the multiply/divide unit
interface muldiv_unit_if #(parameter int DATA_W = 32);
    logic              Start;
    logic [1:0]        Op;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              Flush;
    logic              MtHi;
    logic              MtLo;
    logic [DATA_W-1:0] MtData;
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] Hi;
    logic [DATA_W-1:0] Lo;

    modport master (
        output Start, Op, A, B, Flush, MtHi, MtLo, MtData,
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B, Flush, MtHi, MtLo, MtData,
        output Busy, Done, Hi, Lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
// Signed ops are computed on magnitudes and sign-corrected in FIX.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input logic          Clk,
    input logic          Reset,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t              state, stateNext;
    logic [1:0]          opReg;
    logic                signA, signB;
    logic [DATA_W-1:0]   divisor;
    logic [2*DATA_W-1:0] work;
    logic [CNT_W-1:0]    count;
    logic                doneReg;
    logic [DATA_W-1:0]   hiReg, loReg;

    logic                aNeg, bNeg, startOk;
    logic [DATA_W-1:0]   absA, absB;
    logic [DATA_W:0]     mulSum, divShift, divDiff;
    logic [2*DATA_W-1:0] workStep, prodFix;
    logic [DATA_W-1:0]   quotFix, remFix, resHi, resLo;

    always_comb begin
        startOk = bus.Start && !bus.Flush;
        aNeg    = !bus.Op[0] && bus.A[DATA_W-1];
        bNeg    = !bus.Op[0] && bus.B[DATA_W-1];
        absA    = aNeg ? -bus.A : bus.A;
        absB    = bNeg ? -bus.B : bus.B;
    end

    // work holds {upper partial, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        mulSum   = {1'b0, work[2*DATA_W-1:DATA_W]} + (work[0] ? {1'b0, divisor} : '0);
        divShift = {work[2*DATA_W-1:DATA_W], work[DATA_W-1]};
        divDiff  = divShift - {1'b0, divisor};
        if (!opReg[1])
            workStep = {mulSum, work[DATA_W-1:1]};
        else if (!divDiff[DATA_W])
            workStep = {divDiff[DATA_W-1:0], work[DATA_W-2:0], 1'b1};
        else
            workStep = {divShift[DATA_W-1:0], work[DATA_W-2:0], 1'b0};
    end

    // Divide by zero keeps an unnegated all-ones quotient; remainder then equals A
    always_comb begin
        prodFix = (signA ^ signB) ? -work : work;
        quotFix = ((signA ^ signB) && (divisor != '0)) ? -work[DATA_W-1:0] : work[DATA_W-1:0];
        remFix  = signA ? -work[2*DATA_W-1:DATA_W] : work[2*DATA_W-1:DATA_W];
        if (opReg[1]) begin
            resHi = remFix;
            resLo = quotFix;
        end else begin
            resHi = prodFix[2*DATA_W-1:DATA_W];
            resLo = prodFix[DATA_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (startOk) stateNext = CALC;
            CALC:    if (bus.Flush) stateNext = IDLE;
                     else if (count == LAST) stateNext = FIX;
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            opReg   <= '0;
            signA   <= 1'b0;
            signB   <= 1'b0;
            divisor <= '0;
            work    <= '0;
            count   <= '0;
            doneReg <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.MtHi) hiReg <= bus.MtData;
                    if (bus.MtLo) loReg <= bus.MtData;
                    if (startOk) begin
                        opReg   <= bus.Op;
                        signA   <= aNeg;
                        signB   <= bNeg;
                        divisor <= absB;
                        work    <= {{DATA_W{1'b0}}, absA};
                        count   <= '0;
                    end
                end
                CALC: begin
                    if (!bus.Flush) begin
                        work  <= workStep;
                        count <= count + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!bus.Flush) begin
                        hiReg   <= resHi;
                        loReg   <= resLo;
                        doneReg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy = (state != IDLE);
    assign bus.Done = doneReg;
    assign bus.Hi   = hiReg;
    assign bus.Lo   = loReg;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;
    logic Clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad = 0;

    muldiv_unit_if #(.DATA_W(32)) bus ();
    muldiv_unit #(.DATA_W(32)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo, input string name);
        int  doneAt;
        bit  busyOk;
        @(negedge Clk);
        bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
        @(posedge Clk); #1;
        bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.Op = 2'($urandom);
        busyOk = bus.Busy;
        doneAt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge Clk); #1;
            if (bus.Done) begin
                doneAt = k;
                break;
            end
            if (!bus.Busy) busyOk = 1'b0;
        end
        check({name, " latency"}, doneAt, 33);
        check({name, " busy window"}, busyOk, 1);
        check({name, " busy after done"}, bus.Busy, 0);
        check({name, " hi"}, bus.Hi, expHi);
        check({name, " lo"}, bus.Lo, expLo);
        @(posedge Clk); #1;
        check({name, " done single"}, bus.Done, 0);
    endtask

    task automatic watchNoDone(input string name, input int cycles);
        bit seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge Clk); #1;
            if (bus.Done) seen = 1'b1;
        end
        check({name, " no done"}, seen, 0);
    endtask

    initial begin
        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{2'b11, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
        vecs[5]  = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6]  = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[7]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[8]  = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[9]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        Reset = 1'b1;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.A = '0; bus.B = '0;
        bus.Flush = 1'b0; bus.MtHi = 1'b0; bus.MtLo = 1'b0; bus.MtData = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset busy", bus.Busy, 0);
        check("reset done", bus.Done, 0);
        check("reset hi", bus.Hi, 0);
        check("reset lo", bus.Lo, 0);
        @(negedge Clk); Reset = 1'b0;

        for (int i = 0; i < 12; i++)
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo,
                  $sformatf("vec%0d", i));

        // Flush and Start together in IDLE: nothing starts
        @(negedge Clk); bus.Start = 1'b1; bus.Flush = 1'b1; bus.Op = 2'b01; bus.A = 32'd9; bus.B = 32'd9;
        @(posedge Clk); #1;
        check("flush beats start", bus.Busy, 0);
        bus.Start = 1'b0; bus.Flush = 1'b0;

        // Preload HI/LO, then flush a MULTU mid-flight
        @(negedge Clk); bus.MtHi = 1'b1; bus.MtData = 32'h11111111;
        @(negedge Clk); bus.MtHi = 1'b0; bus.MtLo = 1'b1; bus.MtData = 32'h22222222;
        @(negedge Clk); bus.MtLo = 1'b0;
        check("preload hi", bus.Hi, 32'h11111111);
        check("preload lo", bus.Lo, 32'h22222222);
        bus.Start = 1'b1; bus.Op = 2'b01; bus.A = 32'd3; bus.B = 32'd4;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        check("flush op busy", bus.Busy, 1);
        repeat (9) @(posedge Clk);
        @(negedge Clk); bus.Flush = 1'b1;
        @(posedge Clk); #1;
        bus.Flush = 1'b0;
        check("flush busy", bus.Busy, 0);
        check("flush done", bus.Done, 0);
        check("flush hi kept", bus.Hi, 32'h11111111);
        check("flush lo kept", bus.Lo, 32'h22222222);
        watchNoDone("flush", 40);
        runOp(2'b01, 32'd3, 32'd4, 32'h0, 32'h0000000C, "retry");

        // MtHi with Start: write lands now, result overwrites later
        @(negedge Clk);
        bus.Start = 1'b1; bus.MtHi = 1'b1; bus.MtData = 32'hAAAA5555;
        bus.Op = 2'b01; bus.A = 32'd2; bus.B = 32'd3;
        @(posedge Clk); #1;
        bus.Start = 1'b0; bus.MtHi = 1'b0;
        check("mt with start hi", bus.Hi, 32'hAAAA5555);
        check("mt with start busy", bus.Busy, 1);
        begin
            int doneAt = 0;
            for (int k = 1; k <= 40; k++) begin
                @(posedge Clk); #1;
                if (bus.Done) begin doneAt = k; break; end
            end
            check("mt with start latency", doneAt, 33);
            check("mt with start result hi", bus.Hi, 0);
            check("mt with start result lo", bus.Lo, 6);
        end

        // Reset mid DIVU, MtLo while busy ignored
        @(negedge Clk); bus.Start = 1'b1; bus.Op = 2'b11; bus.A = 32'd100; bus.B = 32'd7;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        @(posedge Clk);
        @(negedge Clk); bus.MtLo = 1'b1; bus.MtData = 32'hDEADBEEF;
        @(posedge Clk); #1;
        bus.MtLo = 1'b0;
        check("mtlo while busy", bus.Lo, 32'h00000006);
        @(posedge Clk);
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check("midreset busy", bus.Busy, 0);
        check("midreset hi", bus.Hi, 0);
        check("midreset lo", bus.Lo, 0);
        watchNoDone("midreset", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
